// File: rtl/jk_pkg.sv
// Shared JK definitions: the {J,K} operation encoding and the JK-to-D
// next-state function used by every flop in the bank.
package jk_pkg;

  typedef enum logic [1:0] {
    HOLD   = 2'b00,
    RESET  = 2'b01,
    SET    = 2'b10,
    TOGGLE = 2'b11
  } jk_op_e;

  // Equivalent to D = (J & ~Q) | (~K & Q), spelled out per operation.
  function automatic logic jk_next(input logic j, input logic k, input logic q);
    jk_op_e op;
    logic   d;
    op = jk_op_e'({j, k});
    d  = q;
    case (op)
      HOLD:   d = q;
      RESET:  d = 1'b0;
      SET:    d = 1'b1;
      TOGGLE: d = ~q;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/d_ff.sv
// Single-bit D flop with a synchronous active-high reset to a per-bit value.
module d_ff (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic d,
  output logic q
);

  logic q_d;
  logic q_q;

  always_comb begin
    q_d = d;
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= rst_val;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/jk_using_d.sv
// Bank of WIDTH independent JK flops, each a d_ff fed by JK-to-D logic.
module jk_using_d
  import jk_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_n
);

  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      q_d[i] = jk_next(J[i], K[i], Q[i]);
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    d_ff u_ff (
      .clk     (clk),
      .rst     (rst),
      .rst_val (RESET_VAL[g]),
      .d       (q_d[g]),
      .q       (Q[g])
    );
  end

  assign Q_n = ~Q;

endmodule

// File: tb/tb_jk_using_d.sv
// Self-checking bench: four jk_using_d configurations against a truth-table model.
module tb_jk_using_d;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // w1: WIDTH=1 RESET_VAL=0; r1: WIDTH=1 RESET_VAL=1; w4: WIDTH=4; w8: WIDTH=8
  logic       rst_w1 = 1'b1, rst_r1 = 1'b1, rst_w4 = 1'b1, rst_w8 = 1'b1;
  logic [0:0] j_w1 = '0, k_w1 = '0, q_w1, qn_w1;
  logic [0:0] j_r1 = '0, k_r1 = '0, q_r1, qn_r1;
  logic [3:0] j_w4 = '0, k_w4 = '0, q_w4, qn_w4;
  logic [7:0] j_w8 = '0, k_w8 = '0, q_w8, qn_w8;

  jk_using_d #(.WIDTH(1), .RESET_VAL(1'b0)) dut_w1 (
    .clk(clk), .rst(rst_w1), .J(j_w1), .K(k_w1), .Q(q_w1), .Q_n(qn_w1));
  jk_using_d #(.WIDTH(1), .RESET_VAL(1'b1)) dut_r1 (
    .clk(clk), .rst(rst_r1), .J(j_r1), .K(k_r1), .Q(q_r1), .Q_n(qn_r1));
  jk_using_d #(.WIDTH(4), .RESET_VAL(4'b0000)) dut_w4 (
    .clk(clk), .rst(rst_w4), .J(j_w4), .K(k_w4), .Q(q_w4), .Q_n(qn_w4));
  jk_using_d #(.WIDTH(8), .RESET_VAL(8'hA5)) dut_w8 (
    .clk(clk), .rst(rst_w8), .J(j_w8), .K(k_w8), .Q(q_w8), .Q_n(qn_w8));

  // Model: hold when neither input set, set when only J, toggle when both, else clear.
  function automatic logic [7:0] model_next(input logic [7:0] q, input logic [7:0] j,
                                            input logic [7:0] k, input logic [7:0] rv,
                                            input logic r);
    if (r) return rv;
    return (q & ~j & ~k) | (j & ~k) | (~q & j & k);
  endfunction

  logic [7:0] m_w1, m_r1, m_w4, m_w8;
  bit v_w1 = 0, v_r1 = 0, v_w4 = 0, v_w8 = 0;

  always @(posedge clk) begin
    m_w1 <= model_next(m_w1, {7'b0, j_w1}, {7'b0, k_w1}, 8'h00, rst_w1) & 8'h01;
    m_r1 <= model_next(m_r1, {7'b0, j_r1}, {7'b0, k_r1}, 8'h01, rst_r1) & 8'h01;
    m_w4 <= model_next(m_w4, {4'b0, j_w4}, {4'b0, k_w4}, 8'h00, rst_w4) & 8'h0F;
    m_w8 <= model_next(m_w8, j_w8, k_w8, 8'hA5, rst_w8);
    v_w1 <= v_w1 | rst_w1;
    v_r1 <= v_r1 | rst_r1;
    v_w4 <= v_w4 | rst_w4;
    v_w8 <= v_w8 | rst_w8;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Continuous compare against the model on the falling edge.
  always @(negedge clk) begin
    if (v_w1) begin
      chk("w1.Q", {7'b0, q_w1}, m_w1);
      chk("w1.Q_n", {7'b0, qn_w1}, {7'b0, ~m_w1[0]});
    end
    if (v_r1) begin
      chk("r1.Q", {7'b0, q_r1}, m_r1);
      chk("r1.Q_n", {7'b0, qn_r1}, {7'b0, ~m_r1[0]});
    end
    if (v_w4) begin
      chk("w4.Q", {4'b0, q_w4}, m_w4);
      chk("w4.Q_n", {4'b0, qn_w4}, {4'b0, ~m_w4[3:0]});
    end
    if (v_w8) begin
      chk("w8.Q", q_w8, m_w8);
      chk("w8.Q_n", qn_w8, ~m_w8);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with J=K=1 on the single-bit flop: toggle must be ignored.
    j_w1 = 1'b1; k_w1 = 1'b1;
    step();
    chk("rst1.Q", {7'b0, q_w1}, 8'h00);
    chk("rst1.Q_n", {7'b0, qn_w1}, 8'h01);
    chk("rst.w4", {4'b0, q_w4}, 8'h00);
    chk("rst.w8", q_w8, 8'hA5);
    chk("rst.r1", {7'b0, q_r1}, 8'h01);
    step();
    chk("rst2.Q", {7'b0, q_w1}, 8'h00);
    rst_w1 = 1'b0; rst_w8 = 1'b0;

    // Truth table on w1.
    j_w1 = 1'b0; k_w1 = 1'b0; step(); chk("tt.hold", {7'b0, q_w1}, 8'h00);
    j_w1 = 1'b0; k_w1 = 1'b1; step(); chk("tt.reset", {7'b0, q_w1}, 8'h00);
    j_w1 = 1'b1; k_w1 = 1'b0; step(); chk("tt.set", {7'b0, q_w1}, 8'h01);
    j_w1 = 1'b1; k_w1 = 1'b1; step(); chk("tt.tog1", {7'b0, q_w1}, 8'h00);
    step();                          chk("tt.tog2", {7'b0, q_w1}, 8'h01);
    chk("tt.tog2.Q_n", {7'b0, qn_w1}, 8'h00);

    // Hold after set.
    j_w1 = 1'b1; k_w1 = 1'b0; step();
    j_w1 = 1'b0; k_w1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold.after.set", {7'b0, q_w1}, 8'h01);
    end

    // Mid-operation reset on r1 (RESET_VAL=1).
    rst_r1 = 1'b0; j_r1 = 1'b0; k_r1 = 1'b1; step(); chk("mid.clear", {7'b0, q_r1}, 8'h00);
    j_r1 = 1'b1; k_r1 = 1'b1; rst_r1 = 1'b1; step(); chk("mid.rst", {7'b0, q_r1}, 8'h01);
    rst_r1 = 1'b0; step(); chk("mid.tog0", {7'b0, q_r1}, 8'h00);
    step();                chk("mid.tog1", {7'b0, q_r1}, 8'h01);

    // Multi-bit: load 0101, then toggle bit3, set bit2, clear bit1, hold bit0.
    rst_w4 = 1'b0; j_w4 = 4'b0101; k_w4 = 4'b1010; step();
    chk("w4.setup", {4'b0, q_w4}, 8'h05);
    j_w4 = 4'b1100; k_w4 = 4'b1010; step();
    chk("w4.mix.Q", {4'b0, q_w4}, 8'h0D);
    chk("w4.mix.Q_n", {4'b0, qn_w4}, 8'h02);
    j_w4 = 4'b0000; k_w4 = 4'b0000;

    // Random regression on the 8-bit bank.
    for (int i = 0; i < 1000; i++) begin
      j_w8   = 8'($urandom);
      k_w8   = 8'($urandom);
      rst_w8 = ($urandom_range(0, 19) == 0);
      step();
    end
    rst_w8 = 1'b1; step();
    chk("w8.final.rst", q_w8, 8'hA5);
    rst_w8 = 1'b0; j_w8 = 8'hFF; k_w8 = 8'hFF; step();
    chk("w8.final.tog", q_w8, 8'h5A);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
